// File: rtl/sfa_pkg.sv
// sfa_pkg: shared constants and FSM encoding for the
// vector-adder operand fetch path.
package sfa_pkg;

  localparam logic [3:0] OP_LOAD = 4'h1;

  localparam int ADDR_W_DEF = 10;
  localparam int FIFO_DEPTH_DEF = 4;

  localparam logic [31:0] RET_OK_DEF = 32'd10;
  localparam logic [31:0] RET_ERR_DEF = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_RET   = 4'b1000
  } state_t;

endpackage

// File: rtl/sfa_sfifo.sv
// sfa_sfifo: small synchronous FIFO with occupancy count,
// head word always visible on dout.
module sfa_sfifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/sfa_vfetch.sv
// sfa_vfetch: reads PR_SIZE words from BRAMs A/B on LOAD and
// streams them lockstep to the vector adder operand inputs.
module sfa_vfetch
  import sfa_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [31:0] RET_OK     = RET_OK_DEF,
  parameter logic [31:0] RET_ERR    = RET_ERR_DEF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [15:0]       PR_SIZE,
  output logic              sCMD_tready,
  input  logic              sCMD_tvalid,
  input  logic [31:0]       sCMD_tdata,
  input  logic              mRet_tready,
  output logic              mRet_tvalid,
  output logic [31:0]       mRet_tdata,
  output logic              bramA_en,
  output logic [ADDR_W-1:0] bramA_addr,
  input  logic [31:0]       bramA_dout,
  output logic              bramB_en,
  output logic [ADDR_W-1:0] bramB_addr,
  input  logic [31:0]       bramB_dout,
  input  logic              mOut1_tready,
  output logic              mOut1_tvalid,
  output logic [31:0]       mOut1_tdata,
  input  logic              mOut2_tready,
  output logic              mOut2_tvalid,
  output logic [31:0]       mOut2_tdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       i;
  logic [ADDR_W-1:0] base;
  logic [31:0]       ret;
  logic              inflight;

  logic [CW-1:0] cnt1;
  logic [CW-1:0] cnt2;
  logic [CW:0]   occ1;
  logic [CW:0]   occ2;
  logic          full1;
  logic          full2;
  logic          empty1;
  logic          empty2;
  logic          pop1;
  logic          pop2;
  logic          issue;
  logic          last;
  logic [3:0]    opcode;
  logic          unused_sig;

  assign opcode = sCMD_tdata[31:28];
  assign unused_sig = ^{sCMD_tdata[27:ADDR_W], full1, full2};

  // In-flight read counts against both FIFOs so neither can overflow.
  assign occ1 = {1'b0, cnt1} + {{CW{1'b0}}, inflight};
  assign occ2 = {1'b0, cnt2} + {{CW{1'b0}}, inflight};

  assign issue = (state == ST_ISSUE) && !ARESET && (i < len)
              && (occ1 < LIMIT) && (occ2 < LIMIT);
  assign last  = (({1'b0, i} + 17'd1) == {1'b0, len});

  assign bramA_en   = issue;
  assign bramB_en   = issue;
  assign bramA_addr = base + ADDR_W'(i);
  assign bramB_addr = base + ADDR_W'(i);

  assign sCMD_tready = (state == ST_IDLE) && !ARESET;
  assign mRet_tvalid = (state == ST_RET) && !ARESET;
  assign mRet_tdata  = ARESET ? '0 : ret;

  assign mOut1_tvalid = !empty1 && !ARESET;
  assign mOut2_tvalid = !empty2 && !ARESET;
  assign pop1 = mOut1_tvalid && mOut1_tready;
  assign pop2 = mOut2_tvalid && mOut2_tready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= ST_IDLE;
      len      <= '0;
      i        <= '0;
      base     <= '0;
      ret      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      unique case (state)
        ST_IDLE: begin
          if (sCMD_tvalid) begin
            len  <= PR_SIZE;
            base <= sCMD_tdata[ADDR_W-1:0];
            i    <= '0;
            if (opcode != OP_LOAD) begin
              ret   <= RET_ERR;
              state <= ST_RET;
            end else if (PR_SIZE == 16'd0) begin
              ret   <= RET_OK;
              state <= ST_RET;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            i <= i + 16'd1;
            if (last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!inflight && empty1 && empty2) begin
            ret   <= RET_OK;
            state <= ST_RET;
          end
        end
        ST_RET: begin
          if (mRet_tready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sfa_sfifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo1 (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (inflight),
    .din   (bramA_dout),
    .pop   (pop1),
    .dout  (mOut1_tdata),
    .full  (full1),
    .empty (empty1),
    .count (cnt1)
  );

  sfa_sfifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo2 (
    .clk   (ACLK),
    .rst   (ARESET),
    .push  (inflight),
    .din   (bramB_dout),
    .pop   (pop2),
    .dout  (mOut2_tdata),
    .full  (full2),
    .empty (empty2),
    .count (cnt2)
  );

endmodule

// File: tb/tb_sfa_vfetch.sv
// tb_sfa_vfetch: randomized bench for sfa_vfetch with BRAM
// models and a queue-based reference of expected streams.
module tb_sfa_vfetch;

  localparam int AW = 10;
  localparam int DEPTH = 4;
  localparam logic [3:0] LOAD = 4'h1;
  localparam logic [31:0] OK = 32'd10;
  localparam logic [31:0] ERR = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   pr_size = '0;
  logic          cmd_ready;
  logic          cmd_valid = 1'b0;
  logic [31:0]   cmd_data = '0;
  logic          ret_ready = 1'b1;
  logic          ret_valid;
  logic [31:0]   ret_data;
  logic          a_en;
  logic          b_en;
  logic [AW-1:0] a_addr;
  logic [AW-1:0] b_addr;
  logic [31:0]   a_dout = '0;
  logic [31:0]   b_dout = '0;
  logic          o1_ready = 1'b1;
  logic          o1_valid;
  logic [31:0]   o1_data;
  logic          o2_ready = 1'b1;
  logic          o2_valid;
  logic [31:0]   o2_data;

  sfa_vfetch #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK         (clk),
    .ARESET       (rst),
    .PR_SIZE      (pr_size),
    .sCMD_tready  (cmd_ready),
    .sCMD_tvalid  (cmd_valid),
    .sCMD_tdata   (cmd_data),
    .mRet_tready  (ret_ready),
    .mRet_tvalid  (ret_valid),
    .mRet_tdata   (ret_data),
    .bramA_en     (a_en),
    .bramA_addr   (a_addr),
    .bramA_dout   (a_dout),
    .bramB_en     (b_en),
    .bramB_addr   (b_addr),
    .bramB_dout   (b_dout),
    .mOut1_tready (o1_ready),
    .mOut1_tvalid (o1_valid),
    .mOut1_tdata  (o1_data),
    .mOut2_tready (o2_ready),
    .mOut2_tvalid (o2_valid),
    .mOut2_tdata  (o2_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem_a [1024];
  logic [31:0] mem_b [1024];

  always @(posedge clk) begin
    if (a_en) a_dout <= mem_a[a_addr];
    if (b_en) b_dout <= mem_b[b_addr];
  end

  bit   rnd = 1'b0;
  logic rdy1 = 1'b1;
  logic rdy2 = 1'b1;

  always @(posedge clk) begin
    #1;
    o1_ready = rnd ? 1'($urandom_range(0, 1)) : rdy1;
    o2_ready = rnd ? 1'($urandom_range(0, 1)) : rdy2;
  end

  logic [31:0] got1[$];
  logic [31:0] got2[$];
  int          pc1[$];
  int          addrs[$];
  int          vcnt = 0;

  always @(negedge clk) begin
    if (a_en) addrs.push_back(int'(a_addr));
    if (o1_valid || o2_valid) vcnt++;
    if (o1_valid && o1_ready) begin
      got1.push_back(o1_data);
      pc1.push_back(cyc);
    end
    if (o2_valid && o2_ready) got2.push_back(o2_data);
  end

  int tests = 0;
  int fails = 0;

  task automatic send_cmd(input logic [3:0] op, input int base,
                          input int len, output int acc);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data = {op, 18'($urandom), 10'(base)};
    pr_size = 16'(len);
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        acc = cyc + 1;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    pr_size = 16'($urandom);
    tests++;
    if (acc < 0) begin
      fails++;
      $display("FAIL cmd_accept: no ready in 100 cycles, required accept");
    end
  endtask

  task automatic wait_ret(output int rc, output logic [31:0] d);
    rc = -1;
    d = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ret_valid && ret_ready) begin
        rc = cyc;
        d = ret_data;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cmd_ready, ret_valid, o1_valid, o2_valid, a_en, b_en} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outs: got %b required 000000",
               {cmd_ready, ret_valid, o1_valid, o2_valid, a_en, b_en});
    end
    tests++;
    if (ret_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_ret_data: got %h required 0", ret_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_basic;
    int s, s2, e, acc, rc, errs, p0, p3;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = 32'(k);
      mem_b[k] = 32'(100 + k);
    end
    s = got1.size(); s2 = got2.size(); e = addrs.size();
    send_cmd(LOAD, 0, 4, acc);
    wait_ret(rc, d);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (s + k >= got1.size() || got1[s+k] !== 32'(k)) errs++;
      if (s2 + k >= got2.size() || got2[s2+k] !== 32'(100 + k)) errs++;
    end
    tests++;
    if (errs != 0 || got1.size() - s != 4 || got2.size() - s2 != 4) begin
      fails++;
      $display("FAIL basic_data: %0d bad words, counts %0d/%0d required 4/4",
               errs, got1.size() - s, got2.size() - s2);
    end
    p0 = (pc1.size() > s) ? pc1[s] : -1;
    p3 = (pc1.size() > s + 3) ? pc1[s+3] : -1;
    tests++;
    if (p0 !== acc + 2) begin
      fails++;
      $display("FAIL first_valid: cycle %0d required %0d", p0, acc + 2);
    end
    tests++;
    if (p3 !== acc + 5) begin
      fails++;
      $display("FAIL throughput: last pop %0d required %0d", p3, acc + 5);
    end
    tests++;
    if (d !== OK || rc <= p3) begin
      fails++;
      $display("FAIL basic_ret: data %h at %0d required %h after %0d",
               d, rc, OK, p3);
    end
    tests++;
    if (addrs.size() - e != 4) begin
      fails++;
      $display("FAIL basic_reads: got %0d required 4", addrs.size() - e);
    end
  endtask

  task automatic test_backpressure;
    int s, s2, e, e0, win, lead, cur, acc, rc, errs, base;
    logic [31:0] d;
    base = $urandom_range(0, 1023);
    s = got1.size(); s2 = got2.size(); e = addrs.size();
    send_cmd(LOAD, base, 12, acc);
    repeat (2) @(negedge clk);
    rdy2 = 1'b0;
    e0 = addrs.size();
    lead = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      cur = (got1.size() - s) - (got2.size() - s2);
      if (cur > lead) lead = cur;
      if (k == 4) begin
        win = addrs.size() - e0;
        rdy2 = 1'b1;
      end
    end
    wait_ret(rc, d);
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      if (s + k >= got1.size() || got1[s+k] !== mem_a[(base + k) % 1024]) errs++;
      if (s2 + k >= got2.size() || got2[s2+k] !== mem_b[(base + k) % 1024]) errs++;
    end
    tests++;
    if (errs != 0 || got1.size() - s != 12 || got2.size() - s2 != 12) begin
      fails++;
      $display("FAIL bp_data: %0d bad words, counts %0d/%0d required 12/12",
               errs, got1.size() - s, got2.size() - s2);
    end
    tests++;
    if (win >= 5) begin
      fails++;
      $display("FAIL bp_issue_stall: %0d reads in 5 stalled cycles, required <5", win);
    end
    tests++;
    if (lead > DEPTH || lead < 1) begin
      fails++;
      $display("FAIL bp_lead: stream1 lead %0d required 1..%0d", lead, DEPTH);
    end
    tests++;
    if (d !== OK || addrs.size() - e != 12) begin
      fails++;
      $display("FAIL bp_ret: ret %h reads %0d required %h and 12",
               d, addrs.size() - e, OK);
    end
  endtask

  task automatic test_wrap;
    int s, e, acc, rc, errs;
    logic [31:0] d;
    s = got1.size(); e = addrs.size();
    send_cmd(LOAD, 1022, 4, acc);
    wait_ret(rc, d);
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (e + k >= addrs.size() || addrs[e+k] != (1022 + k) % 1024) errs++;
    end
    tests++;
    if (errs != 0 || addrs.size() - e != 4) begin
      fails++;
      $display("FAIL wrap_addr: %0d bad addresses of %0d, required 1022,1023,0,1",
               errs, addrs.size() - e);
    end
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      if (s + k >= got1.size() || got1[s+k] !== mem_a[(1022 + k) % 1024]) errs++;
    end
    tests++;
    if (errs != 0 || d !== OK) begin
      fails++;
      $display("FAIL wrap_data: %0d bad words, ret %h required 0 and %h",
               errs, d, OK);
    end
  endtask

  task automatic test_zero_len;
    int e, v, acc, rc;
    logic [31:0] d;
    e = addrs.size(); v = vcnt;
    send_cmd(LOAD, $urandom_range(0, 1023), 0, acc);
    wait_ret(rc, d);
    tests++;
    if (d !== OK || rc != acc) begin
      fails++;
      $display("FAIL zero_ret: %h at %0d required %h at %0d", d, rc, OK, acc);
    end
    tests++;
    if (addrs.size() != e || vcnt != v) begin
      fails++;
      $display("FAIL zero_quiet: reads %0d valids %0d required 0/0",
               addrs.size() - e, vcnt - v);
    end
    send_cmd(4'h7, $urandom_range(0, 1023), 5, acc);
    wait_ret(rc, d);
    tests++;
    if (d !== ERR || addrs.size() != e) begin
      fails++;
      $display("FAIL bad_opcode: ret %h reads %0d required %h and 0",
               d, addrs.size() - e, ERR);
    end
  endtask

  task automatic test_ret_hold;
    int acc, rc;
    logic [31:0] d;
    ret_ready = 1'b0;
    send_cmd(4'h7, 0, 3, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if ({ret_valid, cmd_ready} !== 2'b10 || ret_data !== ERR) begin
        fails++;
        $display("FAIL ret_hold%0d: valid/ready %b data %h required 10 and %h",
                 k, {ret_valid, cmd_ready}, ret_data, ERR);
      end
    end
    @(posedge clk); #1;
    ret_ready = 1'b1;
    wait_ret(rc, d);
    @(negedge clk);
    tests++;
    if (d !== ERR || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL ret_release: ret %h ready %b required %h and 1",
               d, cmd_ready, ERR);
    end
  endtask

  task automatic test_reset_mid;
    int g1, g2, e, acc, rc, base, errs;
    logic [31:0] d;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
    send_cmd(LOAD, $urandom_range(0, 1023), 20, acc);
    repeat (4) @(negedge clk);
    tests++;
    if ({o1_valid, o2_valid} !== 2'b11) begin
      fails++;
      $display("FAIL mid_filled: valids %b required 11", {o1_valid, o2_valid});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({o1_valid, o2_valid, a_en, b_en, cmd_ready, ret_valid} !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset: outs %b required 000000",
               {o1_valid, o2_valid, a_en, b_en, cmd_ready, ret_valid});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    rdy1 = 1'b1;
    rdy2 = 1'b1;
    g1 = got1.size(); g2 = got2.size(); e = addrs.size();
    repeat (6) @(negedge clk);
    #1;
    tests++;
    if (got1.size() != g1 || got2.size() != g2 || addrs.size() != e) begin
      fails++;
      $display("FAIL post_reset_quiet: pops %0d/%0d reads %0d required 0",
               got1.size() - g1, got2.size() - g2, addrs.size() - e);
    end
    base = $urandom_range(0, 1023);
    for (int k = 0; k < 2; k++) begin
      mem_a[(base + k) % 1024] = $urandom;
      mem_b[(base + k) % 1024] = $urandom;
    end
    send_cmd(LOAD, base, 2, acc);
    wait_ret(rc, d);
    errs = 0;
    for (int k = 0; k < 2; k++) begin
      if (g1 + k >= got1.size() || got1[g1+k] !== mem_a[(base + k) % 1024]) errs++;
      if (g2 + k >= got2.size() || got2[g2+k] !== mem_b[(base + k) % 1024]) errs++;
    end
    tests++;
    if (errs != 0 || got1.size() - g1 != 2 || got2.size() - g2 != 2 || d !== OK) begin
      fails++;
      $display("FAIL post_reset_load: %0d bad, counts %0d/%0d ret %h required 2/2 %h",
               errs, got1.size() - g1, got2.size() - g2, d, OK);
    end
  endtask

  task automatic test_random;
    int s, s2, acc, rc, errs, base, len;
    logic [31:0] d;
    rnd = 1'b1;
    for (int n = 0; n < 8; n++) begin
      base = $urandom_range(0, 1023);
      len = $urandom_range(1, 24);
      s = got1.size(); s2 = got2.size();
      send_cmd(LOAD, base, len, acc);
      wait_ret(rc, d);
      errs = 0;
      for (int k = 0; k < len; k++) begin
        if (s + k >= got1.size() || got1[s+k] !== mem_a[(base + k) % 1024]) errs++;
        if (s2 + k >= got2.size() || got2[s2+k] !== mem_b[(base + k) % 1024]) errs++;
      end
      tests++;
      if (errs != 0 || got1.size() - s != len || got2.size() - s2 != len) begin
        fails++;
        $display("FAIL rand%0d_data: %0d bad, counts %0d/%0d required %0d",
                 n, errs, got1.size() - s, got2.size() - s2, len);
      end
      tests++;
      if (d !== OK) begin
        fails++;
        $display("FAIL rand%0d_ret: got %h required %h", n, d, OK);
      end
    end
    rnd = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem_a[k] = $urandom;
      mem_b[k] = $urandom;
    end
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero_len;
    test_ret_hold;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
